// File: rtl/floppy_pkg.sv
// Shared constants and types for the floppy SD sector responder.
// Sector geometry, drive selects and the transfer state encoding.
package floppy_pkg;

  localparam int         SECTOR_BYTES = 512;
  localparam logic [8:0] LAST_BYTE    = 9'(SECTOR_BYTES - 1);

  localparam logic DRV_INT = 1'b0;
  localparam logic DRV_EXT = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_REQ    = 3'd1,
    RD_EMIT   = 3'd2,
    WR_ADDR   = 3'd3,
    WR_HOLD   = 3'd4,
    WR_SAMPLE = 3'd5,
    WR_REQ    = 3'd6,
    DONE      = 3'd7
  } state_e;

  // Byte offset of a sector within its drive image.
  function automatic logic [19:0] sector_offset(input logic [10:0] lba);
    return {lba, 9'd0};
  endfunction

endpackage

// File: rtl/floppy_sd_responder_if.sv
// Sector request/data bus between the track buffer (master) and the responder (slave).
interface floppy_sd_responder_if;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [10:0] sd_lba;
  logic [7:0]  sd_data_out;
  logic        sd_busy;
  logic        sd_done;
  logic [8:0]  sd_addr;
  logic        sd_data_en;
  logic [7:0]  sd_data_in;

  modport master (
    output sd_rd, sd_wr, sd_lba, sd_data_out,
    input  sd_busy, sd_done, sd_addr, sd_data_en, sd_data_in
  );

  modport slave (
    input  sd_rd, sd_wr, sd_lba, sd_data_out,
    output sd_busy, sd_done, sd_addr, sd_data_en, sd_data_in
  );
endinterface

// File: rtl/floppy_sd_responder.sv
// Serves 512-byte sector reads/writes from the track buffer against a byte-wide
// backing image store, one image region per drive.
module floppy_sd_responder
  import floppy_pkg::*;
#(
  parameter int                ADDR_W = 21,
  parameter logic [ADDR_W-1:0] BASE0  = ADDR_W'(21'h000000),
  parameter logic [ADDR_W-1:0] BASE1  = ADDR_W'(21'h0C8000)
) (
  input  logic                      clk,
  input  logic                      rst,
  floppy_sd_responder_if.slave      sd,
  input  logic [31:0]               img_size0,
  input  logic [31:0]               img_size1,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [7:0]                mem_wdata,
  input  logic [7:0]                mem_rdata,
  input  logic                      mem_ack
);

  state_e            state_q, state_d;
  logic [8:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              in_range_q, in_range_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [8:0]        sd_addr_q, sd_addr_d;
  logic              data_en_q, data_en_d;
  logic [7:0]        data_in_q, data_in_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;

  logic              drv_s;
  logic              rd_op_s;
  logic [31:0]       size_s;
  logic [8:0]        next_idx_s;

  // Next-state and next-output computation for the transfer FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    in_range_d  = in_range_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sd_addr_d   = sd_addr_q;
    data_en_d   = 1'b0;
    data_in_d   = data_in_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    next_idx_s  = idx_q + 9'd1;

    // Drive 0 beats drive 1; read beats write within a drive.
    if (sd.sd_rd[0]) begin
      drv_s   = DRV_INT;
      rd_op_s = 1'b1;
    end else if (sd.sd_wr[0]) begin
      drv_s   = DRV_INT;
      rd_op_s = 1'b0;
    end else if (sd.sd_rd[1]) begin
      drv_s   = DRV_EXT;
      rd_op_s = 1'b1;
    end else begin
      drv_s   = DRV_EXT;
      rd_op_s = 1'b0;
    end
    size_s = (drv_s == DRV_INT) ? img_size0 : img_size1;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if ((sd.sd_rd != 2'b00) || (sd.sd_wr != 2'b00)) begin
          base_d     = ((drv_s == DRV_INT) ? BASE0 : BASE1) + ADDR_W'(sector_offset(sd.sd_lba));
          in_range_d = ({12'd0, sector_offset(sd.sd_lba)} + 32'(SECTOR_BYTES)) <= size_s;
          busy_d     = 1'b1;
          sd_addr_d  = 9'd0;
          idx_d      = 9'd0;
          if (rd_op_s) begin
            state_d    = RD_REQ;
            mem_req_d  = in_range_d;
            mem_we_d   = 1'b0;
            mem_addr_d = base_d;
          end else begin
            state_d = WR_ADDR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        // Out-of-range sectors read back as zeros without touching memory.
        if (!in_range_q) begin
          data_in_d = 8'h00;
          data_en_d = 1'b1;
          sd_addr_d = idx_q;
          state_d   = RD_EMIT;
        end else if (mem_ack) begin
          data_in_d = mem_rdata;
          data_en_d = 1'b1;
          sd_addr_d = idx_q;
          mem_req_d = 1'b0;
          state_d   = RD_EMIT;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_EMIT: begin
        if (idx_q == LAST_BYTE) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          idx_d      = next_idx_s;
          mem_req_d  = in_range_q;
          mem_addr_d = base_q + ADDR_W'(next_idx_s);
          state_d    = RD_REQ;
        end
      end
      WR_ADDR:   state_d = WR_HOLD;
      WR_HOLD:   state_d = WR_SAMPLE;
      WR_SAMPLE: begin
        // The initiator's registered read of sd_addr has settled by now.
        mem_wdata_d = sd.sd_data_out;
        mem_we_d    = 1'b1;
        mem_addr_d  = base_q + ADDR_W'(idx_q);
        mem_req_d   = in_range_q;
        state_d     = WR_REQ;
      end
      WR_REQ: begin
        if (!in_range_q || mem_ack) begin
          mem_req_d = 1'b0;
          if (idx_q == LAST_BYTE) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d     = next_idx_s;
            sd_addr_d = next_idx_s;
            state_d   = WR_ADDR;
          end
        end else begin
          state_d = WR_REQ;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 9'd0;
      base_q      <= '0;
      in_range_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sd_addr_q   <= 9'd0;
      data_en_q   <= 1'b0;
      data_in_q   <= 8'h00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      in_range_q  <= in_range_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sd_addr_q   <= sd_addr_d;
      data_en_q   <= data_en_d;
      data_in_q   <= data_in_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign sd.sd_busy    = busy_q;
  assign sd.sd_done    = done_q;
  assign sd.sd_addr    = sd_addr_q;
  assign sd.sd_data_en = data_en_q;
  assign sd.sd_data_in = data_in_q;
  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;

endmodule
